multi_bit_filter: RTL

- Parametrised N-channel glitch/debounce filter for slow external inputs such as hall sensors, limit switches, infrared break-beam and DIP switches.
- Each channel is synchronised, then its filtered output changes only after the new level has held stable for a programmable number of sample ticks.
- Per-channel rise/fall pulses and an aggregate change flag feed the motor-control and status logic directly, so no downstream edge detectors are needed.

---
 rtl/multi_bit_filter_pkg.sv | 13 +
 rtl/multi_bit_filter_channel.sv | 102 ++++++++++
 rtl/multi_bit_filter.sv | 50 +++++
 3 files changed

// File: rtl/multi_bit_filter_pkg.sv
// Shared constants and helpers for the multi_bit_filter debounce block.
// The runtime threshold port is enabled by MULTI_BIT_FILTER_RUNTIME_THRESH_EN.
package multi_bit_filter_pkg;

    localparam int MAX_CHANNELS    = 32;
    localparam int MAX_SYNC_STAGES = 4;

    // Counter width able to hold every value 0..stable_cnt.
    function automatic int cnt_width(input int stable_cnt);
        return $clog2(stable_cnt + 1);
    endfunction

endpackage

// File: rtl/multi_bit_filter_channel.sv
// One debounce channel: optional synchroniser chain, stability counter and edge pulses.
// With MULTI_BIT_FILTER_RUNTIME_THRESH_EN the threshold comes from the thresh port.
module filter_channel
    import multi_bit_filter_pkg::*;
#(
    parameter int   STABLE_CNT  = 10,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0,
    parameter int   CNT_W       = cnt_width(STABLE_CNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_tick,
    input  logic             bit_in,
`ifdef MULTI_BIT_FILTER_RUNTIME_THRESH_EN
    input  logic [CNT_W-1:0] thresh,
`endif
    output logic             bit_out,
    output logic             rise,
    output logic             fall
);

    logic s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = bit_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            always_comb begin
                sync_d[0] = bit_in;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            // The chain shifts every clock; sample_tick only gates the counter.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q <= {SYNC_STAGES{RESET_VAL}};
                else     sync_q <= sync_d;
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             at_limit;

`ifdef MULTI_BIT_FILTER_RUNTIME_THRESH_EN
    logic [CNT_W-1:0] t_m1;
    // thresh==0 behaves as 1; >= lets a lowered threshold flip on the next differing tick.
    assign t_m1     = (thresh == '0) ? '0 : thresh - CNT_W'(1);
    assign at_limit = (cnt_q >= t_m1);
`else
    localparam logic [CNT_W-1:0] T_M1 = CNT_W'(STABLE_CNT - 1);
    assign at_limit = (cnt_q == T_M1);
`endif

    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sample_tick) begin
            if (s == out_q) begin
                cnt_d = '0;
            end else if (at_limit) begin
                out_d  = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            out_q  <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bit_out = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;

endmodule

// File: rtl/multi_bit_filter.sv
// N-channel glitch/debounce filter with per-channel rise/fall pulses and an aggregate change flag.
// Define MULTI_BIT_FILTER_RUNTIME_THRESH_EN to add the runtime thresh port.
module multi_bit_filter
    import multi_bit_filter_pkg::*;
#(
    parameter int                  CHANNELS    = 8,
    parameter int                  STABLE_CNT  = 10,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0] RESET_VAL   = {CHANNELS{1'b0}},
    localparam int                 CNT_W       = cnt_width(STABLE_CNT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic [CHANNELS-1:0] bit_in,
`ifdef MULTI_BIT_FILTER_RUNTIME_THRESH_EN
    input  logic [CNT_W-1:0]    thresh,
`endif
    output logic [CHANNELS-1:0] bit_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            filter_channel #(
                .STABLE_CNT  (STABLE_CNT),
                .SYNC_STAGES (SYNC_STAGES),
                .RESET_VAL   (RESET_VAL[i]),
                .CNT_W       (CNT_W)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .sample_tick (sample_tick),
                .bit_in      (bit_in[i]),
`ifdef MULTI_BIT_FILTER_RUNTIME_THRESH_EN
                .thresh      (thresh),
`endif
                .bit_out     (bit_out[i]),
                .rise        (rise[i]),
                .fall        (fall[i])
            );
        end
    endgenerate

    // Pulses are already registered, so this flag lines up with them.
    assign any_change = |(rise | fall);

endmodule
